// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the triggered ADC snapshot buffer.
package adc_cap_pkg;

    localparam int DEFAULT_DATA_WIDTH = 128;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT
    } cap_state_t;

    // Zero or anything beyond the buffer size means "fill the whole buffer".
    function automatic int clamp_len(input int len, input int depth_log2);
        int depth;
        depth = 1 << depth_log2;
        if (len == 0 || len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port capture RAM: synchronous write, registered 1-cycle read.
module adc_cap_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // No reset on the array or read register so the tools map it to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered ADC snapshot buffer: arm, capture N beats on trigger, replay over AXI4-Stream.
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | waiting for trig_in with a valid ADC beat (beat 0)
//   CAPTURE | storing valid beats until len_r are held
//   READOUT | replaying stored beats with backpressure
module adc_capture_buffer
    import adc_cap_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  arm,
    input  logic [DEPTH_LOG2:0]   cap_len,
    input  logic                  trig_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           trig_count
);

    localparam int LW = DEPTH_LOG2 + 1;

    cap_state_t state, state_next;

    logic [LW-1:0]         len_r, wr_ptr, rd_ptr;
    logic                  wr_en, rd_en, trig_accept, pop;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  pend, pend_last;
    logic                  out_valid, out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid, skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [1:0]            fill;

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_valid & out_last;
    assign busy          = (state != IDLE);
    assign pop           = out_valid & m_axis_tready;
    assign done          = (state == READOUT) & pop & out_last;
    assign trig_accept   = (state == ARMED) & trig_in & s_axis_tvalid;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = '0;
        case (state)
            IDLE: begin
                if (arm) state_next = ARMED;
            end
            ARMED: begin
                if (trig_accept) begin
                    wr_en      = 1'b1;
                    state_next = (len_r == LW'(1)) ? READOUT : CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_axis_tvalid) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_ptr[DEPTH_LOG2-1:0];
                    if (wr_ptr == len_r - LW'(1)) state_next = READOUT;
                end
            end
            READOUT: begin
                if (pop && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stored entries plus the read in flight; a new read is issued only if it
    // is guaranteed a slot in the two-entry output/skid pair.
    assign fill  = 2'({1'b0, out_valid}) + 2'({1'b0, skid_valid}) + 2'({1'b0, pend});
    assign rd_en = (state == READOUT) && (rd_ptr != len_r) && ((fill - 2'({1'b0, pop})) < 2'd2);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            len_r      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trig_count <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && arm) begin
                len_r  <= LW'(clamp_len(32'(cap_len), DEPTH_LOG2));
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
            if (wr_en)       wr_ptr     <= wr_ptr + LW'(1);
            if (trig_accept) trig_count <= trig_count + 16'd1;
            if (rd_en)       rd_ptr     <= rd_ptr + LW'(1);
            pend      <= rd_en;
            pend_last <= (rd_ptr == len_r - LW'(1));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= pend;
                skid_data  <= ram_rdata;
                skid_last  <= pend_last;
            end else begin
                out_valid <= pend;
                if (pend) begin
                    out_data <= ram_rdata;
                    out_last <= pend_last;
                end
            end
        end else if (pend) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_rdata;
            skid_last  <= pend_last;
        end
    end

    adc_cap_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized self-checking bench for adc_capture_buffer against a queue-based capture model.
module tb_adc_capture_buffer;

    localparam int DW    = 128;
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          arm = 1'b0;
    logic [DL:0]   cap_len = '0;
    logic          trig_in = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   trig_count;

    always #5 aclk = ~aclk;

    adc_capture_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .arm           (arm),
        .cap_len       (cap_len),
        .trig_in       (trig_in),
        .busy          (busy),
        .done          (done),
        .trig_count    (trig_count)
    );

    int total = 0;
    int bad   = 0;

    int cnt       = 0;
    int valid_pct = 100;
    int ready_pct = 100;
    bit hunt      = 0;
    int push_len  = 0;
    int exp_tc    = 0;
    bit b_exp     = 0;
    int rx_n      = 0;
    bit fin       = 0;
    int cyc       = 0;
    int arm_cyc   = 0;
    int first_cyc = -1;
    bit stall     = 0;
    logic [DW-1:0] st_data = '0;
    logic          st_last = 1'b0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] beat(input int v);
        return {32'(v), ~32'(v), 32'(v * 7 + 3), 32'hC0DE_0000 ^ 32'(v)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ADC source: a ramp that advances only on valid beats.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (s_valid) cnt++;
            s_valid = ($urandom_range(99) < valid_pct);
            s_data  = beat(cnt);
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Reference model and per-cycle compare.
    always @(negedge aclk) begin
        bit hs;
        bit lastb;
        cyc++;
        hs    = 0;
        lastb = 0;
        if (!aresetn) begin
            b_exp  = 0;
            stall  = 0;
            exp_tc = 0;
            chk("rst_tvalid", {127'd0, m_valid}, '0);
            chk("rst_busy", {127'd0, busy}, '0);
            chk("rst_done", {127'd0, done}, '0);
            chk("rst_trig_count", {112'd0, trig_count}, '0);
        end else begin
            chk("s_tready", {127'd0, s_ready}, 128'd1);
            chk("trig_count", {112'd0, trig_count}, DW'(exp_tc));
            chk("busy", {127'd0, busy}, {127'd0, b_exp});
            if (stall) begin
                chk("hold_valid", {127'd0, m_valid}, 128'd1);
                chk("hold_data", m_data, st_data);
                chk("hold_last", {127'd0, m_last}, {127'd0, st_last});
            end
            hs = m_valid && m_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    fail("extra_beat", rx_n + 1, rx_n);
                end else begin
                    lastb = (exp_q.size() == 1);
                    chk("beat_data", m_data, exp_q[0]);
                    chk("beat_last", {127'd0, m_last}, {127'd0, lastb});
                    chk("done_pulse", {127'd0, done}, {127'd0, lastb});
                    void'(exp_q.pop_front());
                    rx_n++;
                    if (lastb) fin = 1;
                end
            end else begin
                chk("done_idle", {127'd0, done}, '0);
            end
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            stall   = m_valid && !m_ready;
            st_data = m_data;
            st_last = m_last;
            if (!b_exp && arm) begin
                b_exp     = 1;
                arm_cyc   = cyc;
                first_cyc = -1;
            end else if (hs && lastb) begin
                b_exp = 0;
            end
            // Captured snapshot = trigger beat plus the following valid beats.
            if (hunt && trig_in && s_valid) begin
                for (int i = 0; i < push_len; i++) exp_q.push_back(beat(cnt + i));
                exp_tc = (exp_tc + 1) % 65536;
                hunt   = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        hunt    = 0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic run_cap(input int len, input bit with_trig, input int vp, input int rp,
                           input bit rearm, input bit abort, output int got);
        int  el;
        bit  rearmed;
        bit  aborted;
        el        = (len == 0 || len > DEPTH) ? DEPTH : len;
        valid_pct = vp;
        ready_pct = rp;
        rearmed   = 0;
        aborted   = 0;
        @(posedge aclk);
        #1;
        arm      = 1'b1;
        cap_len  = (DL+1)'(len);
        trig_in  = with_trig;
        rx_n     = 0;
        fin      = 0;
        push_len = el;
        @(posedge aclk);
        #1;
        arm     = 1'b0;
        trig_in = 1'b1;
        hunt    = 1;
        for (int i = 0; i < 30000; i++) begin
            @(posedge aclk);
            #1;
            arm = 1'b0;
            if (fin) break;
            if (rearm && rx_n == 3 && !rearmed) begin
                arm     = 1'b1;
                cap_len = (DL+1)'(4);
                rearmed = 1;
            end
            if (abort && rx_n == 5) begin
                do_reset();
                aborted = 1;
                break;
            end
        end
        trig_in = 1'b0;
        arm     = 1'b0;
        if (!abort) begin
            if (!fin) fail("capture_timeout", rx_n, el);
            chk("beats_received", DW'(rx_n), DW'(el));
            chk("queue_drained", DW'(exp_q.size()), '0);
        end else if (!aborted) begin
            fail("abort_not_reached", rx_n, 5);
        end
        got = rx_n;
    endtask

    initial begin
        int got;
        repeat (3) @(negedge aclk);
        chk("reset_tvalid", {127'd0, m_valid}, '0);
        chk("reset_tdata", m_data, '0);
        chk("reset_tlast", {127'd0, m_last}, '0);
        chk("reset_busy", {127'd0, busy}, '0);
        chk("reset_done", {127'd0, done}, '0);
        chk("reset_trig_count", {112'd0, trig_count}, '0);
        chk("reset_s_tready", {127'd0, s_ready}, 128'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Basic 16-beat capture: trigger in the cycle after arm, tvalid 19 cycles after arm.
        run_cap(16, 0, 100, 100, 0, 0, got);
        chk("t1_beats", DW'(got), 128'd16);
        chk("t1_latency", DW'(first_cyc - arm_cyc), 128'd19);
        chk("t1_trig_count", {112'd0, trig_count}, 128'd1);

        run_cap(16, 0, 50, 100, 0, 0, got);
        run_cap(16, 0, 100, 70, 0, 0, got);
        run_cap(40, 0, 60, 70, 0, 0, got);

        run_cap(0, 0, 100, 100, 0, 0, got);
        chk("len0_clamp", DW'(got), 128'd1024);
        run_cap(2000, 0, 80, 90, 0, 0, got);
        chk("len2000_clamp", DW'(got), 128'd1024);
        run_cap(1, 0, 100, 100, 0, 0, got);
        chk("len1_single", DW'(got), 128'd1);

        // arm+trig together must not accept the trigger in the arm cycle.
        do_reset();
        run_cap(16, 1, 100, 100, 1, 0, got);
        chk("t5_latency", DW'(first_cyc - arm_cyc), 128'd19);
        chk("t5_trig_count", {112'd0, trig_count}, 128'd1);

        run_cap(16, 0, 100, 80, 0, 1, got);
        @(negedge aclk);
        chk("abort_tvalid", {127'd0, m_valid}, '0);
        chk("abort_busy", {127'd0, busy}, '0);
        run_cap(20, 0, 70, 70, 0, 0, got);
        chk("rearm_beats", DW'(got), 128'd20);

        for (int k = 0; k < 12; k++) begin
            int l;
            l = ($urandom_range(3) == 0) ? $urandom_range(2047) : $urandom_range(64, 1);
            run_cap(l, $urandom_range(1), $urandom_range(100, 30), $urandom_range(100, 40), 0, 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Triggered snapshot buffer between one RFDC ADC AXI4-Stream output and the PS-side AXI4-Stream capture/DMA port, in the `aclk` (375 MHz) domain. Software arms it; a trigger qualifier (SYSREF-aligned `sysref_reg` or a software strobe) starts the capture of a programmed number of ADC beats into block RAM. The stored beats are then replayed over an AXI4-Stream master with full backpressure support and `tlast` on the final beat.

## Interface
Parameters:
- `DATA_WIDTH`, 128: beat width (8 × 16-bit samples).
- `DEPTH_LOG2`, 10: buffer depth is 2^DEPTH_LOG2 beats (1024).

Ports:
- `aclk` in 1: single clock; all logic is on this clock.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `s_axis_tdata` in DATA_WIDTH: ADC beat.
- `s_axis_tvalid` in 1: ADC beat valid.
- `s_axis_tready` out 1: constant 1. The ADC stream is never stalled.
- `m_axis_tdata` out DATA_WIDTH: replayed beat.
- `m_axis_tvalid` out 1: replayed beat valid.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tlast` out 1: high on the final replayed beat.
- `arm` in 1: one-cycle pulse that starts a capture cycle.
- `cap_len` in DEPTH_LOG2+1: number of beats to capture, sampled on `arm`. A value of 0 or any value above 2^DEPTH_LOG2 is clamped to 2^DEPTH_LOG2.
- `trig_in` in 1: trigger qualifier; level-sensitive while ARMED.
- `busy` out 1: high in ARMED, CAPTURE and READOUT.
- `done` out 1: one-cycle pulse on the final m_axis handshake.
- `trig_count` out 16: count of accepted triggers; wraps from 0xFFFF to 0.

## Operation
States (enum): IDLE, ARMED, CAPTURE, READOUT.
- **IDLE**
  - `arm` latches the clamped length into `len_r` and moves to ARMED.
  - `trig_in` is ignored.
- **ARMED**
  - Waits for a cycle with `trig_in` and `s_axis_tvalid` both high.
  - That beat is written to address 0 (it is beat 0 of the capture). `trig_count` increments.
  - If `len_r` = 1, go directly to READOUT; otherwise go to CAPTURE.
  - `arm` and `trig_in` high in the same cycle while in IDLE: arm only. The trigger is not accepted until the next cycle.
- **CAPTURE**
  - Each cycle with `s_axis_tvalid` high writes the beat to address `wr_ptr` and increments `wr_ptr`. Cycles with tvalid low write nothing and do not advance.
  - After the write of beat `len_r`-1, go to READOUT.
  - `trig_in` and `arm` are ignored.
- **READOUT**
  - Beats are read from address 0 upward. `m_axis_tlast` is high on beat `len_r`-1.
  - The handshake of the final beat pulses `done` and returns to IDLE.
  - `arm` is ignored.
- **AXI rules**
  - Once `m_axis_tvalid` is high, it and `m_axis_tdata`/`m_axis_tlast` hold stable until `m_axis_tready`.
  - No bubbles while `m_axis_tready` stays high. This requires a 2-entry prefetch/skid stage behind the 1-cycle RAM read.
- **Reset**
  - `aresetn` low at any time, including mid-CAPTURE or mid-READOUT, forces IDLE and clears all pointers and counters.
  - Buffer contents are not cleared.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done` = 0.
  - `m_axis_tdata` = 0.
  - `trig_count` = 0.
  - `s_axis_tready` = 1.
- `busy` rises the cycle after `arm` and falls the cycle after the final handshake.
- First `m_axis_tvalid` rises 2 cycles after entering READOUT: one cycle for the RAM address, one for RAM data into the output register.
- Throughput: 1 beat per cycle under continuous `m_axis_tready`.
- Capture latency: the trigger beat is written in the same cycle it is accepted. The final capture write is followed by READOUT in the next cycle.
- Read-before-write hazards cannot occur; CAPTURE and READOUT never overlap.

## Structure
- Package `adc_cap_pkg`: state enum `cap_state_t`, `DEFAULT_DATA_WIDTH`, `DEFAULT_DEPTH_LOG2`, and the `cap_len` clamp function.
- Sub-module `adc_cap_ram`: simple dual-port RAM, synchronous write, 1-cycle registered read, inferred as BRAM.
- Top level holds the FSM, pointers, trigger counter and output skid stage.

## Test plan
- `arm` with `cap_len`=16, trigger on ramp data 0..N, `m_axis_tready`=1 -> 16 beats equal to the ramp starting at the trigger beat, `tlast` on beat 15, `done` pulse, `trig_count`=1.
- Same capture with `s_axis_tvalid` toggling 50% during CAPTURE -> only valid beats stored, output is 16 contiguous ramp values.
- Random `m_axis_tready` (30% low) during READOUT -> data and `tlast` stable while stalled, no lost or duplicated beat.
- `cap_len`=0 and `cap_len`=2000 -> both capture exactly 1024 beats. `cap_len`=1 -> a single beat with `tlast` set.
- `arm` and `trig_in` together, then `trig_in` held -> capture starts one cycle later. Second `arm` during READOUT -> ignored, `trig_count` stays 1.
- `aresetn` pulsed at beat 5 of READOUT -> `m_axis_tvalid`=0 and IDLE immediately. Re-arm -> a correct fresh capture.
